mux_n_para_1_registrado: RTL and testbench
==========================================

// Module: mux_n_para_1_registrado
// PURPOSE
//  Parametrised N-input, W-bit multiplexer with a registered output stage and valid/ready handshake on
//  every input and on the output. Selection is either explicit (external selecao) or round-robin
//  among valid inputs. Used on datapath paths that cross a pipeline boundary, and to merge producers.
// PARAMETERS
//  LARGURA       8   data width of each input and of saida
//  NUM_ENTRADAS  4   number of input channels, >= 2; SEL_W = $clog2(NUM_ENTRADAS) (localparam)
//  MODO          0   0 = explicit selection via selecao; 1 = round-robin over valid channels
// PORTS
//  clock           in   1                     rising-edge clock
//  reset           in   1                     asynchronous, active-high reset
//  entradas        in   NUM_ENTRADAS*LARGURA  packed data; channel i = entradas[i*LARGURA +: LARGURA]
//  entrada_valida  in   NUM_ENTRADAS          per-channel valid
//  entrada_pronta  out  NUM_ENTRADAS          per-channel ready; at most one bit high per cycle
//  selecao         in   SEL_W                 selected channel (MODO=0 only, ignored in MODO=1)
//  saida           out  LARGURA               registered output data
//  saida_valida    out  1                     saida holds a word
//  saida_pronta    in   1                     consumer accepts saida this cycle
//  canal_atual     out  SEL_W                 channel index the held word came from
// BEHAVIOUR
//  - Reset (async, immediate): saida=0, saida_valida=0, canal_atual=0, round-robin pointer ptr=0.
//    A held word is discarded; a reset mid-handshake completes no transfer.
//  - Output register states: VAZIO (saida_valida=0), CHEIO (saida_valida=1).
//    pode_aceitar = !saida_valida || saida_pronta.
//  - Grant (combinational): MODO=0: g = selecao; no grant if selecao >= NUM_ENTRADAS.
//    MODO=1: g = first i with entrada_valida[i], searching ptr, ptr+1, ... wrapping mod NUM_ENTRADAS;
//    no grant if no channel is valid.
//  - entrada_pronta[g] = pode_aceitar; all other bits 0. In MODO=1, entrada_pronta depends
//    combinationally on entrada_valida; producers must not make valid depend on ready.
//  - Accept = grant exists && entrada_valida[g] && pode_aceitar. On accept at edge k:
//    saida <= channel g data, canal_atual <= g, saida_valida <= 1 (visible after edge k; 1-cycle latency).
//    MODO=1 also: ptr <= (g == NUM_ENTRADAS-1) ? 0 : g+1. ptr is unchanged when there is no accept.
//  - Drain without accept (saida_valida && saida_pronta && !accept): saida_valida <= 0.
//    saida and canal_atual keep their last value.
//  - Simultaneous drain and accept: the new word replaces the old word; saida_valida stays 1.
//    Throughput is 1 word/cycle with no bubble.
//  - Back-pressure (saida_valida && !saida_pronta): saida and canal_atual stay stable.
//    All entrada_pronta bits are 0. Changes on entradas or selecao do not affect the held word.
//  - saida_pronta while VAZIO has no effect. Unselected channels' data is never sampled.
// TESTING
//  1. MODO=0, N=4, W=8: selecao=2, ch2=0xA5 valid, saida_pronta=0
//     -> next cycle saida=0xA5, valida=1, canal_atual=2; entrada_pronta=4'b0000 while held.
//  2. While 1 is held: change ch2 to 0x3C, selecao to 1 for 3 cycles
//     -> saida stays 0xA5; then saida_pronta=1 -> 0x3C? no: ch1 data is loaded on that same edge.
//  3. MODO=0 streaming: ch1 values 0x01, 0x02, 0x03 on consecutive cycles, saida_pronta=1
//     -> saida 0x01, 0x02, 0x03 on consecutive cycles; valida stays 1; no bubble.
//  4. MODO=1: all 4 channels valid continuously, saida_pronta=1
//     -> canal_atual 0, 1, 2, 3, 0, 1 ...
//     Only ch1 and ch3 valid after ptr=2 -> grants 3, 1, 3.
//  5. N=3, MODO=0: selecao=3 with all valid -> entrada_pronta=0, saida_valida stays 0.
//  6. Assert reset asynchronously between edges while CHEIO
//     -> saida=0, valida=0, canal_atual=0 immediately; in MODO=1, the first post-reset grant is the lowest valid channel.

Source files
------------

// File: rtl/mux_n_para_1_registrado.sv
// mux_n_para_1_registrado
//   N-input, W-bit multiplexer with a registered output stage and a valid/ready
//   handshake on every input and on the output. The channel is either chosen
//   explicitly through selecao (MODO=0) or by a round-robin search over the
//   valid channels that starts at an internal pointer (MODO=1).
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   entradas       in   packed data, channel i = entradas[i*LARGURA +: LARGURA]
//   entrada_valida in   per-channel valid
//   entrada_pronta out  per-channel ready, at most one bit high (combinational)
//   selecao        in   selected channel (MODO=0 only)
//   saida          out  registered output data
//   saida_valida   out  saida holds a word
//   saida_pronta   in   consumer accepts saida this cycle
//   canal_atual    out  channel the held word came from
module mux_n_para_1_registrado #(
  parameter int LARGURA      = 8,
  parameter int NUM_ENTRADAS = 4,
  parameter int MODO         = 0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_ENTRADAS*LARGURA-1:0]   entradas,
  input  logic [NUM_ENTRADAS-1:0]           entrada_valida,
  output logic [NUM_ENTRADAS-1:0]           entrada_pronta,
  input  logic [$clog2(NUM_ENTRADAS)-1:0]   selecao,
  output logic [LARGURA-1:0]                saida,
  output logic                              saida_valida,
  input  logic                              saida_pronta,
  output logic [$clog2(NUM_ENTRADAS)-1:0]   canal_atual
);

  localparam int SEL_W = $clog2(NUM_ENTRADAS);

  typedef enum logic [0:0] {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_t;

  estado_t              r_estado;
  estado_t              w_estado_prox;
  logic [LARGURA-1:0]   r_saida;
  logic [SEL_W-1:0]     r_canal;
  logic [SEL_W-1:0]     r_ptr;

  logic                 w_pode_aceitar;
  logic                 w_grant_ok;
  logic [SEL_W-1:0]     w_grant;
  logic [SEL_W-1:0]     w_idx;
  int                   w_soma;
  logic [LARGURA-1:0]   w_dado_g;
  logic                 w_valida_g;
  logic                 w_accept;

  assign w_pode_aceitar = (r_estado == VAZIO) || saida_pronta;

  // Grant: explicit selection, or first valid channel at or after the pointer.
  always_comb begin
    w_grant_ok = 1'b0;
    w_grant    = '0;
    w_idx      = '0;
    w_soma     = 0;
    if (MODO == 0) begin
      w_grant    = selecao;
      w_grant_ok = (int'(selecao) < NUM_ENTRADAS);
    end else begin
      // Scan from the farthest offset down so the closest valid channel wins.
      for (int k = NUM_ENTRADAS - 1; k >= 0; k--) begin
        w_soma = int'(r_ptr) + k;
        w_soma = (w_soma >= NUM_ENTRADAS) ? (w_soma - NUM_ENTRADAS) : w_soma;
        w_idx  = w_soma[SEL_W-1:0];
        if (entrada_valida[w_idx]) begin
          w_grant_ok = 1'b1;
          w_grant    = w_idx;
        end else begin
          w_grant_ok = w_grant_ok;
        end
      end
    end
  end

  // Route the granted channel's data/valid and drive the single ready bit.
  always_comb begin
    w_dado_g       = '0;
    w_valida_g     = 1'b0;
    entrada_pronta = '0;
    for (int i = 0; i < NUM_ENTRADAS; i++) begin
      if (w_grant_ok && (w_grant == SEL_W'(i))) begin
        w_dado_g          = entradas[i*LARGURA +: LARGURA];
        w_valida_g        = entrada_valida[i];
        entrada_pronta[i] = w_pode_aceitar;
      end else begin
        entrada_pronta[i] = 1'b0;
      end
    end
  end

  assign w_accept = w_grant_ok && w_valida_g && w_pode_aceitar;

  // Next state of the output register: a drain and an accept together keep it full.
  always_comb begin
    w_estado_prox = r_estado;
    case (r_estado)
      VAZIO: begin
        if (w_accept) w_estado_prox = CHEIO;
        else          w_estado_prox = VAZIO;
      end
      CHEIO: begin
        if (w_accept)          w_estado_prox = CHEIO;
        else if (saida_pronta) w_estado_prox = VAZIO;
        else                   w_estado_prox = CHEIO;
      end
      default: w_estado_prox = VAZIO;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= VAZIO;
    else       r_estado <= w_estado_prox;
  end

  // Held word and its source channel; only an accept overwrites them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_saida <= '0;
      r_canal <= '0;
    end else if (w_accept) begin
      r_saida <= w_dado_g;
      r_canal <= w_grant;
    end else begin
      r_saida <= r_saida;
      r_canal <= r_canal;
    end
  end

  // Round-robin pointer: moves just past the channel that was served.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_accept && (MODO == 1)) begin
      if (w_grant == SEL_W'(NUM_ENTRADAS - 1)) r_ptr <= '0;
      else                                     r_ptr <= w_grant + SEL_W'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign saida        = r_saida;
  assign canal_atual  = r_canal;
  assign saida_valida = (r_estado == CHEIO);

endmodule

// File: tb/tb_mux_n_para_1_registrado.sv
// Bench for mux_n_para_1_registrado: three instances (N=4 explicit, N=4
// round-robin, N=3 explicit) share inputs and are compared every cycle with a
// behavioural model, plus directed scenarios with fixed expected values.
module tb_mux_n_para_1_registrado;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ent;
  logic [3:0]  vld;
  logic [1:0]  sel;
  logic [2:0]  pr;

  logic [3:0] ep0, ep1;
  logic [2:0] ep2;
  logic [7:0] s0, s1, s2;
  logic       v0, v1, v2;
  logic [1:0] c0, c1, c2;

  logic [3:0] ep_all [3];
  logic [7:0] sa_all [3];
  logic       va_all [3];
  logic [1:0] ca_all [3];

  int checks = 0;
  int failures = 0;

  int  cfg_n    [3] = '{4, 4, 3};
  int  cfg_modo [3] = '{0, 1, 0};
  logic       m_v   [3];
  logic [7:0] m_d   [3];
  int         m_c   [3];
  int         m_ptr [3];

  always #5 clock = ~clock;

  mux_n_para_1_registrado #(.LARGURA(8), .NUM_ENTRADAS(4), .MODO(0)) u_dut0 (
    .clock(clock), .reset(reset), .entradas(ent), .entrada_valida(vld),
    .entrada_pronta(ep0), .selecao(sel), .saida(s0), .saida_valida(v0),
    .saida_pronta(pr[0]), .canal_atual(c0));

  mux_n_para_1_registrado #(.LARGURA(8), .NUM_ENTRADAS(4), .MODO(1)) u_dut1 (
    .clock(clock), .reset(reset), .entradas(ent), .entrada_valida(vld),
    .entrada_pronta(ep1), .selecao(sel), .saida(s1), .saida_valida(v1),
    .saida_pronta(pr[1]), .canal_atual(c1));

  mux_n_para_1_registrado #(.LARGURA(8), .NUM_ENTRADAS(3), .MODO(0)) u_dut2 (
    .clock(clock), .reset(reset), .entradas(ent[23:0]), .entrada_valida(vld[2:0]),
    .entrada_pronta(ep2), .selecao(sel), .saida(s2), .saida_valida(v2),
    .saida_pronta(pr[2]), .canal_atual(c2));

  assign ep_all[0] = ep0;
  assign ep_all[1] = ep1;
  assign ep_all[2] = {1'b0, ep2};
  assign sa_all[0] = s0;
  assign sa_all[1] = s1;
  assign sa_all[2] = s2;
  assign va_all[0] = v0;
  assign va_all[1] = v1;
  assign va_all[2] = v2;
  assign ca_all[0] = c0;
  assign ca_all[1] = c1;
  assign ca_all[2] = c2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Channel granted by the rules: explicit index if in range, otherwise the
  // first valid channel found walking forward from the pointer. -1 = none.
  function automatic int grant_of(input int n, input int modo, input logic [3:0] v,
                                  input int s, input int p);
    int idx;
    if (modo == 0) return (s < n) ? s : -1;
    for (int k = 0; k < n; k++) begin
      idx = (p + k) % n;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_v[d] = 1'b0; m_d[d] = 8'h00; m_c[d] = 0; m_ptr[d] = 0;
    end
  endtask

  task automatic chk_outputs(input string pfx);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_saida%0d", pfx, d), 32'(sa_all[d]), 32'(m_d[d]));
      chk($sformatf("%s_valida%0d", pfx, d), 32'(va_all[d]), 32'(m_v[d]));
      chk($sformatf("%s_canal%0d", pfx, d), 32'(ca_all[d]), 32'(m_c[d]));
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next one.
  task automatic cycle();
    int         g   [3];
    logic       acc [3];
    logic       pode;
    logic [3:0] e;
    logic [3:0] vmask;
    #1;
    for (int d = 0; d < 3; d++) begin
      vmask  = (cfg_n[d] == 3) ? (vld & 4'b0111) : vld;
      g[d]   = grant_of(cfg_n[d], cfg_modo[d], vmask, int'(sel), m_ptr[d]);
      pode   = !m_v[d] || pr[d];
      e      = 4'b0000;
      if (g[d] >= 0 && pode) e = 4'b0001 << g[d];
      acc[d] = (g[d] >= 0) && vmask[g[d]] && pode;
      chk($sformatf("pronta%0d", d), 32'(ep_all[d]), 32'(e));
    end
    @(posedge clock);
    for (int d = 0; d < 3; d++) begin
      if (acc[d]) begin
        m_v[d] = 1'b1;
        m_d[d] = ent[g[d]*8 +: 8];
        m_c[d] = g[d];
        if (cfg_modo[d] == 1) m_ptr[d] = (g[d] == cfg_n[d] - 1) ? 0 : g[d] + 1;
      end else if (m_v[d] && pr[d]) begin
        m_v[d] = 1'b0;
      end
    end
    @(negedge clock);
    chk_outputs("cyc");
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_outputs("rst");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ent = 32'h0; vld = 4'h0; sel = 2'd0; pr = 3'b000;
    model_reset();
    #3;
    chk_outputs("init");
    @(negedge clock);
    reset = 1'b0;

    // Explicit select of channel 2 with the consumer stalled.
    sel = 2'd2; ent = 32'h00A5_0000; vld = 4'b0100; pr = 3'b000;
    cycle();
    chk("t1_saida", 32'(s0), 32'h0000_00A5);
    chk("t1_canal", 32'(c0), 32'd2);

    // Held word is immune to input changes under back-pressure.
    sel = 2'd1; ent = 32'h003C_7700; vld = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t2_hold", 32'(s0), 32'h0000_00A5);
    end
    pr = 3'b111;
    cycle();
    chk("t2_load", 32'(s0), 32'h0000_0077);
    chk("t2_canal", 32'(c0), 32'd1);

    // Back-to-back words with no bubble.
    for (int k = 1; k <= 3; k++) begin
      ent = 32'(k) << 8;
      cycle();
      chk("t3_saida", 32'(s0), 32'(k));
      chk("t3_valida", 32'(v0), 32'd1);
    end

    // Round-robin with every channel valid, then only channels 1 and 3.
    do_reset();
    sel = 2'd3; vld = 4'hF; pr = 3'b111; ent = 32'h4433_2211;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("t4_rr", 32'(c1), 32'(k % 4));
    end
    vld = 4'b1010;
    cycle(); chk("t4_rr13", 32'(c1), 32'd3);
    cycle(); chk("t4_rr13", 32'(c1), 32'd1);
    cycle(); chk("t4_rr13", 32'(c1), 32'd3);

    // Out-of-range selection on the 3-input instance never grants.
    chk("t5_valida", 32'(v2), 32'd0);
    chk("t5_pronta", 32'(ep2), 32'd0);

    // Reset while full, then the first grant is the lowest valid channel.
    pr = 3'b000;
    cycle();
    do_reset();
    vld = 4'b0110; pr = 3'b111;
    cycle();
    chk("t6_first", 32'(c1), 32'd1);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      ent = $urandom;
      vld = 4'($urandom);
      sel = 2'($urandom);
      pr  = 3'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
